// File: rtl/sdp_ram_clr.sv
// Simple dual-port RAM with per-lane write enables, 1- or 2-cycle registered read,
// selectable read-during-write behaviour and an optional post-reset clear sweep.
module sdp_ram_clr #(
   parameter int unsigned          DATA_BITS      = 14,
   parameter int unsigned          ADDR_BITS      = 6,
   parameter int unsigned          BYTE_BITS      = DATA_BITS,
   parameter int unsigned          READ_LATENCY   = 1,
   parameter bit                   RDW_NEW        = 1'b0,
   parameter bit                   CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_BITS-1:0] CLEAR_VALUE    = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_BITS-1:0]           wr_addr,
   input  logic [DATA_BITS-1:0]           wr_data,
   input  logic                           wr_en,
   input  logic [DATA_BITS/BYTE_BITS-1:0] wr_be,
   input  logic [ADDR_BITS-1:0]           rd_addr,
   input  logic                           rd_en,
   output logic [DATA_BITS-1:0]           rd_data,
   output logic                           rd_valid,
   output logic                           busy
);

   localparam int unsigned LANES = DATA_BITS / BYTE_BITS;
   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                 state, state_next;
   logic [ADDR_BITS-1:0]   clr_addr;
   logic [DATA_BITS-1:0]   mem [DEPTH];
   logic [DATA_BITS-1:0]   wr_word;
   logic [DATA_BITS-1:0]   rd_word;
   logic                   wr_acc;
   logic                   rd_acc;
   logic [DATA_BITS-1:0]   pipe_data;
   logic                   pipe_valid;

   // busy mirrors state == CLEAR, so it doubles as the request gate
   assign wr_acc = wr_en & ~busy & ~rst;
   assign rd_acc = rd_en & ~busy & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
         clr_addr <= '0;
         busy     <= CLEAR_ON_RESET;
      end else begin
         state <= state_next;
         busy  <= (state_next == CLEAR);
         if (state == CLEAR)
            clr_addr <= clr_addr + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         CLEAR:   if (clr_addr == '1) state_next = IDLE;
         default: state_next = state;
      endcase
   end

   always_comb begin
      wr_word = mem[wr_addr];
      for (int unsigned i = 0; i < LANES; i++)
         if (wr_be[i])
            wr_word[i*BYTE_BITS +: BYTE_BITS] = wr_data[i*BYTE_BITS +: BYTE_BITS];
   end

   always_comb begin
      rd_word = mem[rd_addr];
      if (RDW_NEW && wr_acc && (wr_addr == rd_addr))
         rd_word = wr_word;
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR && !rst)
         mem[clr_addr] <= CLEAR_VALUE;
      else if (wr_acc)
         mem[wr_addr] <= wr_word;
   end

   if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk) begin
         if (rst) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
         end else begin
            pipe_valid <= rd_acc;
            if (rd_acc)
               pipe_data <= rd_word;
         end
      end
   end else begin : g_lat1
      always_comb begin
         pipe_valid = rd_acc;
         pipe_data  = rd_word;
      end
   end

   // Output register holds rd_data between valid pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= pipe_valid;
         if (pipe_valid)
            rd_data <= pipe_data;
      end
   end

endmodule

// File: tb/tb_sdp_ram_clr.sv
// Bench for sdp_ram_clr: three configurations share stimulus; a reference model
// queues expected reads per instance and a negedge monitor retires them.
module tb_sdp_ram_clr;

   logic        clk;
   logic        rst;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_en;
   logic [1:0]  wr_be;
   logic [3:0]  rd_addr;
   logic        rd_en;

   logic [15:0] rdd [3];
   logic        rv  [3];
   logic        bz  [3];

   int checks;
   int errors;
   int cyc;

   typedef struct {
      logic [15:0] d;
      int          due;
      bit          chk;
   } exp_t;

   exp_t        q [3][$];
   logic [15:0] last [3];
   logic [15:0] mem1 [16];
   logic [15:0] mem2 [16];
   logic [1:0]  kn2  [16];
   logic        mbusy;
   logic [3:0]  mcnt;

   // 0: latency 1, old-data RDW; 1: latency 2, new-data RDW; 2: no clear sweep
   sdp_ram_clr #(.DATA_BITS(16), .ADDR_BITS(4), .BYTE_BITS(8), .READ_LATENCY(1),
                 .RDW_NEW(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut0 (
      .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .wr_be(wr_be), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rdd[0]),
      .rd_valid(rv[0]), .busy(bz[0]));

   sdp_ram_clr #(.DATA_BITS(16), .ADDR_BITS(4), .BYTE_BITS(8), .READ_LATENCY(2),
                 .RDW_NEW(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut1 (
      .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .wr_be(wr_be), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rdd[1]),
      .rd_valid(rv[1]), .busy(bz[1]));

   sdp_ram_clr #(.DATA_BITS(16), .ADDR_BITS(4), .BYTE_BITS(8), .READ_LATENCY(1),
                 .RDW_NEW(0), .CLEAR_ON_RESET(0), .CLEAR_VALUE(16'hA5A5)) dut2 (
      .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .wr_be(wr_be), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rdd[2]),
      .rd_valid(rv[2]), .busy(bz[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                         input logic [1:0] be);
      merge = o;
      if (be[0]) merge[7:0]  = d[7:0];
      if (be[1]) merge[15:8] = d[15:8];
   endfunction

   // Reference model: expected rd_valid cycle is the accepting edge count + latency - 1
   initial begin
      cyc   = 0;
      mbusy = 1'b0;
      mcnt  = '0;
      for (int i = 0; i < 16; i++) kn2[i] = 2'b00;
   end

   always @(posedge clk) begin : model
      logic [15:0] old;
      logic [15:0] nw;
      cyc = cyc + 1;
      if (rst) begin
         mbusy = 1'b1;
         mcnt  = '0;
         for (int i = 0; i < 3; i++) begin
            q[i].delete();
            last[i] = 16'h0000;
         end
      end else begin
         if (mbusy) begin
            mem1[mcnt] = 16'hA5A5;
            if (mcnt == 4'd15) mbusy = 1'b0;
            mcnt = mcnt + 4'd1;
         end else begin
            if (rd_en) begin
               old = mem1[rd_addr];
               nw  = (wr_en && wr_addr == rd_addr) ? merge(old, wr_data, wr_be) : old;
               q[0].push_back('{old, cyc, 1'b1});
               q[1].push_back('{nw, cyc + 1, 1'b1});
            end
            if (wr_en) mem1[wr_addr] = merge(mem1[wr_addr], wr_data, wr_be);
         end
         if (rd_en) q[2].push_back('{mem2[rd_addr], cyc, kn2[rd_addr] == 2'b11});
         if (wr_en) begin
            mem2[wr_addr] = merge(mem2[wr_addr], wr_data, wr_be);
            kn2[wr_addr]  = kn2[wr_addr] | wr_be;
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      logic eb;
      for (int i = 0; i < 3; i++) begin
         eb = (i == 2) ? 1'b0 : mbusy;
         checks++;
         if (bz[i] !== eb) begin
            errors++;
            $display("FAIL busy inst%0d cyc%0d: got %b expected %b", i, cyc, bz[i], eb);
         end
         if (rv[i] === 1'b1) begin
            if (q[i].size() == 0 || q[i][0].due != cyc) begin
               errors++;
               $display("FAIL unexpected_rd_valid inst%0d cyc%0d: got 1 expected 0", i, cyc);
            end else begin
               e = q[i].pop_front();
               if (e.chk) begin
                  checks++;
                  if (rdd[i] !== e.d) begin
                     errors++;
                     $display("FAIL rd_data inst%0d cyc%0d: got %h expected %h", i, cyc, rdd[i], e.d);
                  end
                  last[i] = e.d;
               end else begin
                  last[i] = 'x;
               end
            end
         end else begin
            if (q[i].size() > 0 && q[i][0].due == cyc) begin
               errors++;
               $display("FAIL missing_rd_valid inst%0d cyc%0d: got %b expected 1", i, cyc, rv[i]);
               void'(q[i].pop_front());
            end
            if (!$isunknown(last[i])) begin
               checks++;
               if (rdd[i] !== last[i]) begin
                  errors++;
                  $display("FAIL rd_data_hold inst%0d cyc%0d: got %h expected %h", i, cyc, rdd[i], last[i]);
               end
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_be   = 2'b00;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
      wr_en   = 1'b1;
      cycle();
      idle();
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (bz[0] === 1'b1 && n < 40) begin
         n++;
         cycle();
      end
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      cycle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rv[i] !== 1'b0 || rdd[i] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs inst%0d: got valid=%b data=%h expected valid=0 data=0000", i, rv[i], rdd[i]);
         end
      end
      checks++;
      if (bz[0] !== 1'b1 || bz[1] !== 1'b1 || bz[2] !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b%b%b expected 110", bz[0], bz[1], bz[2]);
      end
      rst = 1'b0;
   endtask

   task automatic test_sweep();
      int n;
      int pulses;
      count_busy(n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL sweep_busy_cycles: got %0d expected 16", n);
      end
      pulses = 0;
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         rd_en   = 1'b1;
         cycle();
         if (rv[0] === 1'b1) pulses++;
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         cycle();
         if (rv[0] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 16) begin
         errors++;
         $display("FAIL sweep_read_pulses: got %0d expected 16", pulses);
      end
   endtask

   task automatic test_byte_enable();
      do_write(4'd3, 16'h1234, 2'b11);
      do_write(4'd3, 16'hABCD, 2'b01);
      rd_addr = 4'd3;
      rd_en   = 1'b1;
      cycle();
      idle();
      checks++;
      if (rv[0] !== 1'b1 || rdd[0] !== 16'h12CD) begin
         errors++;
         $display("FAIL byte_enable: got valid=%b data=%h expected valid=1 data=12cd", rv[0], rdd[0]);
      end
      do_write(4'd3, 16'hFFFF, 2'b00);
      cycle();
   endtask

   task automatic test_rdw();
      do_write(4'd5, 16'h1111, 2'b11);
      wr_addr = 4'd5;
      wr_data = 16'h2222;
      wr_be   = 2'b10;
      wr_en   = 1'b1;
      rd_addr = 4'd5;
      rd_en   = 1'b1;
      cycle();
      idle();
      checks++;
      if (rv[0] !== 1'b1 || rdd[0] !== 16'h1111) begin
         errors++;
         $display("FAIL rdw_old: got valid=%b data=%h expected valid=1 data=1111", rv[0], rdd[0]);
      end
      cycle();
      checks++;
      if (rv[1] !== 1'b1 || rdd[1] !== 16'h2211) begin
         errors++;
         $display("FAIL rdw_new: got valid=%b data=%h expected valid=1 data=2211", rv[1], rdd[1]);
      end
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [4:0] v0;
      logic [4:0] v1;
      for (int a = 0; a < 3; a++) do_write(4'(a), 16'h1000 + 16'(a), 2'b11);
      rd_addr = 4'd0;
      rd_en   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         v0[k] = rv[0];
         v1[k] = rv[1];
         if (k < 2) rd_addr = 4'(k + 1);
         else       rd_en   = 1'b0;
      end
      idle();
      checks++;
      if (v0 !== 5'b00111) begin
         errors++;
         $display("FAIL latency1_valid_pattern: got %b expected 00111", v0);
      end
      checks++;
      if (v1 !== 5'b01110) begin
         errors++;
         $display("FAIL latency2_valid_pattern: got %b expected 01110", v1);
      end
   endtask

   task automatic attempt();
      wr_addr = 4'd4;
      wr_data = 16'hFFFF;
      wr_be   = 2'b11;
      wr_en   = 1'b1;
      rd_addr = 4'd4;
      rd_en   = 1'b1;
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      attempt();
      repeat (6) cycle();
      idle();
      rst = 1'b1;
      cycle();
      checks++;
      if (bz[0] !== 1'b1) begin
         errors++;
         $display("FAIL midsweep_busy_in_reset: got %b expected 1", bz[0]);
      end
      rst = 1'b0;
      attempt();
      n = 0;
      while (bz[0] === 1'b1 && n < 40) begin
         checks++;
         if (rv[0] !== 1'b0 || rv[1] !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_no_valid: got %b%b expected 00", rv[0], rv[1]);
         end
         n++;
         cycle();
      end
      idle();
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL midsweep_busy_cycles: got %0d expected 16", n);
      end
      rd_addr = 4'd4;
      rd_en   = 1'b1;
      cycle();
      idle();
      checks++;
      if (rv[0] !== 1'b1 || rdd[0] !== 16'hA5A5) begin
         errors++;
         $display("FAIL midsweep_write_ignored: got valid=%b data=%h expected valid=1 data=a5a5", rv[0], rdd[0]);
      end
      cycle();
   endtask

   task automatic test_no_clear();
      int n;
      do_write(4'd9, 16'hBEEF, 2'b11);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (bz[2] !== 1'b0) begin
         errors++;
         $display("FAIL noclear_busy: got %b expected 0", bz[2]);
      end
      rd_addr = 4'd9;
      rd_en   = 1'b1;
      cycle();
      idle();
      checks++;
      if (rv[2] !== 1'b1 || rdd[2] !== 16'hBEEF) begin
         errors++;
         $display("FAIL noclear_keep: got valid=%b data=%h expected valid=1 data=beef", rv[2], rdd[2]);
      end
      count_busy(n);
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL noclear_other_sweep: got %0d expected 15", n);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle();
      rst = 1'b1;
      test_reset();
      test_sweep();
      test_byte_enable();
      test_rdw();
      test_back_to_back();
      test_reset_mid_sweep();
      test_no_clear();
      repeat (4) cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
